// File: rtl/cordic_mag_phase.sv
// Streaming IQ-to-polar converter: quadrant fold, STAGES vectoring CORDIC iterations,
// then gain correction and saturation. All stages advance together on a shared enable.
module cordic_mag_phase #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 14
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic [2*WIDTH-1:0] i_tdata,
   input  logic               i_tlast,
   input  logic               i_tvalid,
   output logic               i_tready,
   output logic [2*WIDTH-1:0] o_tdata,
   output logic               o_tlast,
   output logic               o_tvalid,
   input  logic               o_tready
);

   localparam int XW = WIDTH + 2;
   localparam int PW = XW + 17;
   localparam logic signed [16:0]   GAIN = 17'sd19899;
   localparam logic signed [XW-1:0] Z_PI = {2'b00, 1'b1, {(WIDTH-1){1'b0}}};

   // atan(2^-k) with pi = 2^15, rescaled to pi = 2^(WIDTH-1)
   function automatic logic signed [XW-1:0] atan_lut(input int k);
      logic [15:0] t;
      logic [63:0] w;
      case (k)
         0:       t = 16'd8192;
         1:       t = 16'd4836;
         2:       t = 16'd2555;
         3:       t = 16'd1297;
         4:       t = 16'd651;
         5:       t = 16'd326;
         6:       t = 16'd163;
         7:       t = 16'd81;
         8:       t = 16'd41;
         9:       t = 16'd20;
         10:      t = 16'd10;
         11:      t = 16'd5;
         12:      t = 16'd3;
         13:      t = 16'd1;
         14:      t = 16'd1;
         default: t = 16'd0;
      endcase
      w = (64'(t) << WIDTH) >> 16;
      return w[XW-1:0];
   endfunction

   logic                 en;
   logic signed [XW-1:0] i_ext;
   logic signed [XW-1:0] q_ext;
   logic signed [XW-1:0] x_q [0:STAGES];
   logic signed [XW-1:0] y_q [0:STAGES];
   logic signed [XW-1:0] z_q [0:STAGES];
   logic [STAGES:0]      v_q;
   logic [STAGES:0]      l_q;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] mag_full;
   logic [WIDTH-1:0]     mag;

   assign en       = o_tready | ~o_tvalid;
   assign i_tready = en;
   assign i_ext    = {{2{i_tdata[2*WIDTH-1]}}, i_tdata[2*WIDTH-1:WIDTH]};
   assign q_ext    = {{2{i_tdata[WIDTH-1]}}, i_tdata[WIDTH-1:0]};

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         v_q      <= '0;
         l_q      <= '0;
         o_tvalid <= 1'b0;
         o_tlast  <= 1'b0;
      end else if (en) begin
         v_q      <= {v_q[STAGES-1:0], i_tvalid};
         l_q      <= {l_q[STAGES-1:0], i_tvalid & i_tlast};
         o_tvalid <= v_q[STAGES];
         o_tlast  <= l_q[STAGES];
      end
   end

   // Left half-plane inputs are rotated by pi so the iterations only ever see x >= 0.
   always_ff @(posedge clk) begin
      if (en) begin
         if (i_tvalid) begin
            if (i_ext[XW-1]) begin
               x_q[0] <= -i_ext;
               y_q[0] <= -q_ext;
               z_q[0] <= q_ext[XW-1] ? -Z_PI : Z_PI;
            end else begin
               x_q[0] <= i_ext;
               y_q[0] <= q_ext;
               z_q[0] <= '0;
            end
         end
         for (int k = 0; k < STAGES; k++) begin
            if (!y_q[k][XW-1]) begin
               x_q[k+1] <= x_q[k] + (y_q[k] >>> k);
               y_q[k+1] <= y_q[k] - (x_q[k] >>> k);
               z_q[k+1] <= z_q[k] + atan_lut(k);
            end else begin
               x_q[k+1] <= x_q[k] - (y_q[k] >>> k);
               y_q[k+1] <= y_q[k] + (x_q[k] >>> k);
               z_q[k+1] <= z_q[k] - atan_lut(k);
            end
         end
      end
   end

   assign prod     = PW'(x_q[STAGES]) * PW'(GAIN);
   assign mag_full = prod >>> 15;

   always_comb begin
      mag = mag_full[WIDTH-1:0];
      if (mag_full[PW-1]) begin
         mag = '0;
      end else if (|mag_full[PW-2:WIDTH-1]) begin
         mag = {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   // Phase keeps only the low WIDTH bits, so +pi wraps onto -pi.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_tdata <= '0;
      end else if (en && v_q[STAGES]) begin
         o_tdata <= {mag, z_q[STAGES][WIDTH-1:0]};
      end
   end

endmodule

// File: doc/cordic_mag_phase.md
Name: cordic_mag_phase

Overview:
- Streaming IQ-to-polar converter that sits directly upstream of the per-channel predistorter.
- Accepts complex samples {I, Q} on AXI-stream and runs a pipelined vectoring CORDIC.
- Emits {magnitude, phase}. The predistorter consumes the magnitude from bits [31:16]; phase in [15:0] is kept for later re-rotation.
- Fully pipelined: 1 sample per clock when not back-pressured.

Parameters:
- WIDTH, 16, bit width of each of I, Q, magnitude and phase.
- STAGES, 14, number of CORDIC micro-rotation iterations (valid range 8..WIDTH).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous pipeline flush; same effect as reset on valid/last state.
- i_tdata  input  2*WIDTH  {I[31:16], Q[15:0]}, two's complement.
- i_tlast  input  1  end of packet.
- i_tvalid  input  1  input beat valid.
- i_tready  output  1  input beat accepted when high together with i_tvalid.
- o_tdata  output  2*WIDTH  {mag[31:16] unsigned saturated to 0..2^(WIDTH-1)-1, phase[15:0] signed}.
- o_tlast  output  1  tlast delayed in lockstep with its sample.
- o_tvalid  output  1  output beat valid.
- o_tready  input  1  downstream ready.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, on clk / reset.
- Reset values: o_tvalid=0, o_tlast=0, o_tdata=0, all internal valid bits 0. i_tready=1 after reset, since the pipeline is empty.
- Pipeline enable: en = o_tready | ~o_tvalid; i_tready = en.
  - When en=0, every stage holds its contents, including valid and last.
  - Input is captured only when i_tvalid & en.
- Latency is STAGES+2 enabled cycles:
  - Stage 0: quadrant fold.
  - Stages 1..STAGES: iterations.
  - Final stage: gain correct and saturate.
- Stage 0 (fold):
  - Sign-extend I and Q to WIDTH+2 bits.
  - If I<0: x=-I, y=-Q; z0=+2^(WIDTH-1) if Q>=0, else -2^(WIDTH-1), in WIDTH+2-bit phase space.
  - Otherwise x=I, y=Q, z0=0.
  - Negating -2^(WIDTH-1) must not overflow; the extended width covers it.
- Stage k (k=0..STAGES-1):
  - If y>=0: x+=y>>>k, y-=x>>>k, z+=atan_k.
  - Else: x-=y>>>k, y+=x>>>k, z-=atan_k.
  - Shifts are arithmetic.
  - atan_k = round(atan(2^-k) * 2^(WIDTH-1)/pi), a constant table; phase scale is 2^(WIDTH-1) = pi.
- Final stage:
  - mag = (x * 19899) >>> 15, where 19899 = round(2^15/1.646760).
  - Saturate mag to 2^(WIDTH-1)-1.
  - phase = z wrapped to WIDTH bits, so +pi maps to -2^(WIDTH-1).
- Accuracy at STAGES=14: |mag - true| <= 3 LSB; |phase - true| <= 4 LSB, with wrap-around at +/-pi counted modulo 2^WIDTH.
- tlast travels in a shift register parallel to the valid bits; it is never reordered, dropped or merged.
- Handshake rules:
  - o_tvalid, once asserted, stays high with o_tdata/o_tlast stable until o_tready.
  - Input and output transfers in the same cycle are both honoured, so throughput is 1/clk.
- Bubbles: empty slots are not compressed except at the output stage. With en=1, a bubble simply propagates.
- clear or reset mid-packet:
  - All valid and last bits go to 0 on the next edge.
  - No partial or stale beats emerge afterwards.
  - Data registers need not clear.
- Input (0,0): mag=0; phase is don't-care but must be deterministic (0 for the given algorithm).

Test Plan:
- (I=16384, Q=0) single beat, o_tready=1 -> after 16 cycles mag=16384±3, phase=0±4, o_tlast follows i_tlast.
- (0, 16384) and (0, -16384) -> mag 16384±3; phase +16384±4 and -16384±4 respectively.
- (-16384, 0) -> mag 16384±3; phase within 4 LSB of -32768 (modulo 2^16, so 32764..32767 also accepted). (-32768, -32768) -> mag saturates to 32767, phase -24576±4.
- 20-beat packet, o_tready toggled low for 10 cycles mid-stream:
  - All 20 beats appear in order with no duplicates.
  - o_tdata is stable while stalled.
  - o_tlast is only on beat 20.
  - i_tready is low exactly while o_tvalid & ~o_tready.
- Continuous random IQ at o_tready=1 -> one output per clock after 16-cycle fill; every result is within tolerance of the double-precision reference model.
- Assert reset (then separately clear) for 1 cycle with 10 beats in flight -> o_tvalid=0 on the next cycle, zero further outputs until new input, and the next beat's result is correct.
